// File: rtl/exec_stage_pipe.sv
// Y86 execute stage with a registered, valid/ready result slot, a condition-code
// register feeding Cnd, and an iterative shift-add multiply for OPQ ifun 4.
module exec_stage_pipe #(
    parameter int WIDTH      = 64,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       icode_i,
    input  logic [3:0]       ifun_i,
    input  logic [WIDTH-1:0] valA_i,
    input  logic [WIDTH-1:0] valB_i,
    input  logic [WIDTH-1:0] valC_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [3:0]       icode_o,
    output logic [WIDTH-1:0] valE_o,
    output logic             Cnd_o,
    output logic [2:0]       cc_o,
    output logic             busy_o
);

    localparam int MSB   = WIDTH - 1;
    localparam int CHUNK = WIDTH / MUL_CYCLES;
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;
    localparam logic [3:0] F_MUL = 4'h4;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [WIDTH-1:0] STEP_POS = WIDTH'(WIDTH / 8);
    localparam logic [WIDTH-1:0] STEP_NEG = ~STEP_POS + WIDTH'(1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q;
    logic               out_valid_q;
    logic [3:0]         icode_q;
    logic [WIDTH-1:0]   valE_q;
    logic               cnd_q;
    logic [2:0]         cc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   mcand_q, mplier_q, mul_acc_q;

    logic               accept;
    logic [WIDTH-1:0]   alu_a, alu_b, alu_res;
    logic [3:0]         alu_fn;
    logic               alu_of;
    logic               cc_wr, is_mul, cond_ok, cnd_eval;
    logic [WIDTH-1:0]   mul_part, mul_acc_d, mcand_d, mplier_d;
    logic               mul_done;

    // The slot is reserved for the multiply: no accepts while it iterates.
    assign in_ready_o = (state_q != S_MUL) & (~out_valid_q | out_ready_i);
    assign accept     = in_valid_i & in_ready_o;

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (icode_i)
            I_RRMOVQ:          alu_a = valA_i;
            I_IRMOVQ:          alu_a = valC_i;
            I_RMMOVQ, I_MRMOVQ: begin alu_a = valC_i;   alu_b = valB_i; end
            I_OPQ:             begin alu_a = valA_i;   alu_b = valB_i; end
            I_CALL, I_PUSHQ:   begin alu_a = STEP_NEG; alu_b = valB_i; end
            I_RET, I_POPQ:     begin alu_a = STEP_POS; alu_b = valB_i; end
            default: ;
        endcase
    end

    assign alu_fn = (icode_i == I_OPQ) ? ifun_i : F_ADD;
    assign cc_wr  = (icode_i == I_OPQ) && (ifun_i <= F_XOR);
    assign is_mul = (icode_i == I_OPQ) && (ifun_i == F_MUL);

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        case (alu_fn)
            F_ADD: begin
                alu_res = alu_b + alu_a;
                alu_of  = (alu_a[MSB] == alu_b[MSB]) && (alu_res[MSB] != alu_a[MSB]);
            end
            F_SUB: begin
                alu_res = alu_b - alu_a;
                alu_of  = (alu_a[MSB] != alu_b[MSB]) && (alu_res[MSB] != alu_b[MSB]);
            end
            F_AND:   alu_res = alu_b & alu_a;
            F_XOR:   alu_res = alu_b ^ alu_a;
            default: alu_res = '0;
        endcase
    end

    // cc_q is {ZF,SF,OF}; Cnd sees the flags as they stand before this instruction.
    always_comb begin
        case (ifun_i)
            C_YES:   cond_ok = 1'b1;
            C_LE:    cond_ok = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            C_L:     cond_ok = cc_q[1] ^ cc_q[0];
            C_E:     cond_ok = cc_q[2];
            C_NE:    cond_ok = ~cc_q[2];
            C_GE:    cond_ok = ~(cc_q[1] ^ cc_q[0]);
            C_G:     cond_ok = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
            default: cond_ok = 1'b0;
        endcase
    end

    assign cnd_eval = ((icode_i == I_RRMOVQ) || (icode_i == I_JXX)) ? cond_ok : 1'b0;

    // One multiply step: add the multiplicand for each of the next CHUNK multiplier bits.
    always_comb begin
        mul_part = '0;
        for (int j = 0; j < CHUNK; j++) begin
            if (mplier_q[j]) mul_part = mul_part + (mcand_q << j);
        end
    end

    assign mul_acc_d = mul_acc_q + mul_part;
    assign mcand_d   = mcand_q << CHUNK;
    assign mplier_d  = mplier_q >> CHUNK;
    assign mul_done  = (cnt_q == CNT_W'(MUL_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            icode_q     <= 4'h0;
            valE_q      <= '0;
            cnd_q       <= 1'b0;
            cc_q        <= 3'b100;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            mul_acc_q   <= '0;
        end else begin
            if (out_ready_i) out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && is_mul) begin
                        mcand_q   <= alu_a;
                        mplier_q  <= alu_b;
                        mul_acc_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= S_MUL;
                    end else if (accept) begin
                        valE_q      <= alu_res;
                        icode_q     <= icode_i;
                        cnd_q       <= cnd_eval;
                        out_valid_q <= 1'b1;
                        if (cc_wr) cc_q <= {alu_res == '0, alu_res[MSB], alu_of};
                    end
                end
                S_MUL: begin
                    mul_acc_q <= mul_acc_d;
                    mcand_q   <= mcand_d;
                    mplier_q  <= mplier_d;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (mul_done) begin
                        valE_q      <= mul_acc_d;
                        icode_q     <= I_OPQ;
                        cnd_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        cc_q        <= {mul_acc_d == '0, mul_acc_d[MSB], 1'b0};
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign icode_o     = icode_q;
    assign valE_o      = valE_q;
    assign Cnd_o       = cnd_q;
    assign cc_o        = cc_q;
    assign busy_o      = (state_q == S_MUL);

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Bench for exec_stage_pipe: vector table, directed multi-cycle sequences, a
// randomized stream against a plain-arithmetic model, and a 32-bit instance.
module tb_exec_stage_pipe;

    localparam int EW = 72;  // {icode, cnd, cc, valE}

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid_i = 1'b0, in_ready_o;
    logic [3:0]  icode_i = '0, ifun_i = '0;
    logic [63:0] valA_i = '0, valB_i = '0, valC_i = '0;
    logic        out_valid_o, out_ready_i = 1'b1;
    logic [3:0]  icode_o;
    logic [63:0] valE_o;
    logic        Cnd_o, busy_o;
    logic [2:0]  cc_o;

    logic        in_valid_s = 1'b0, in_ready_s;
    logic [3:0]  icode_s = '0, ifun_s = '0;
    logic [31:0] valA_s = '0, valB_s = '0, valC_s = '0;
    logic        out_valid_s, out_ready_s = 1'b1;
    logic [3:0]  icode_os;
    logic [31:0] valE_s;
    logic        cnd_s, busy_s;
    logic [2:0]  cc_s;

    exec_stage_pipe #(.WIDTH(64), .MUL_CYCLES(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .icode_i(icode_i), .ifun_i(ifun_i), .valA_i(valA_i), .valB_i(valB_i), .valC_i(valC_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .icode_o(icode_o),
        .valE_o(valE_o), .Cnd_o(Cnd_o), .cc_o(cc_o), .busy_o(busy_o)
    );

    exec_stage_pipe #(.WIDTH(32), .MUL_CYCLES(8)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n_i), .in_valid_i(in_valid_s), .in_ready_o(in_ready_s),
        .icode_i(icode_s), .ifun_i(ifun_s), .valA_i(valA_s), .valB_i(valB_s), .valC_i(valC_s),
        .out_valid_o(out_valid_s), .out_ready_i(out_ready_s), .icode_o(icode_os),
        .valE_o(valE_s), .Cnd_o(cnd_s), .cc_o(cc_s), .busy_o(busy_s)
    );

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    logic [2:0] m_cc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        icode_i = ic; ifun_i = fn; valA_i = a; valB_i = b; valC_i = c;
    endtask

    // Reference: operand rules and flag meanings in plain signed arithmetic.
    task automatic model(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] va,
                         input logic [63:0] vb, input logic [63:0] vc, output logic [EW-1:0] beat);
        logic [63:0] a, b, e;
        logic signed [127:0] full;
        logic cnd, ovf, upd, zf, sf, of;
        a = '0; b = '0; e = '0; ovf = 1'b0; upd = 1'b0; cnd = 1'b0; full = '0;
        case (ic)
            4'h2:       a = va;
            4'h3:       a = vc;
            4'h4, 4'h5: begin a = vc; b = vb; end
            4'h6:       begin a = va; b = vb; end
            4'h8, 4'hA: begin a = -64'sd8; b = vb; end
            4'h9, 4'hB: begin a = 64'd8; b = vb; end
            default: ;
        endcase
        if (ic == 4'h6) begin
            case (fn)
                4'h0: begin full = $signed(b) + $signed(a); e = full[63:0]; ovf = (full != $signed(e)); upd = 1'b1; end
                4'h1: begin full = $signed(b) - $signed(a); e = full[63:0]; ovf = (full != $signed(e)); upd = 1'b1; end
                4'h2: begin e = b & a; upd = 1'b1; end
                4'h3: begin e = b ^ a; upd = 1'b1; end
                4'h4: begin full = $signed(b) * $signed(a); e = full[63:0]; upd = 1'b1; end
                default: e = '0;
            endcase
        end else begin
            e = b + a;
        end
        {zf, sf, of} = m_cc;
        if (ic == 4'h2 || ic == 4'h7) begin
            case (fn)
                4'h0: cnd = 1'b1;
                4'h1: cnd = (sf ^ of) | zf;
                4'h2: cnd = sf ^ of;
                4'h3: cnd = zf;
                4'h4: cnd = !zf;
                4'h5: cnd = !(sf ^ of);
                4'h6: cnd = !(sf ^ of) && !zf;
                default: cnd = 1'b0;
            endcase
        end
        if (upd) m_cc = {e == 64'd0, e[63], ovf};
        beat = {ic, cnd, m_cc, e};
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 4))
            0: return 64'($urandom_range(0, 16));
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 4));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] a, b, c, e;
        logic        cnd;
        logic [2:0]  cc;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] c, input logic [63:0] e,
                                input logic cnd, input logic [2:0] cc);
        vec_t v;
        v.icode = ic; v.ifun = fn; v.a = a; v.b = b; v.c = c; v.e = e; v.cnd = cnd; v.cc = cc;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        logic [EW-1:0] beat, exp_beat;
        logic pending, seen;
        logic [3:0] r_ic, r_fn;
        logic [63:0] r_a, r_b, r_c;
        int sent, got, cyc;

        vecs.push_back(mk(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'h8000_0000_0000_0000, 0, 3'b011));
        vecs.push_back(mk(4'h6, 4'h1, 64'd5, 64'd5, 0, 64'd0, 0, 3'b100));
        vecs.push_back(mk(4'h7, 4'h3, 0, 0, 0, 64'd0, 1, 3'b100));
        vecs.push_back(mk(4'h7, 4'h4, 0, 0, 0, 64'd0, 0, 3'b100));
        vecs.push_back(mk(4'h6, 4'h2, 64'hF0, 64'h3C, 0, 64'h30, 0, 3'b000));
        vecs.push_back(mk(4'h6, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3'b010));
        vecs.push_back(mk(4'h2, 4'h2, 64'h55, 64'h9, 0, 64'h55, 1, 3'b010));
        vecs.push_back(mk(4'h3, 4'h0, 64'h1, 64'h2, 64'h1234, 64'h1234, 0, 3'b010));
        vecs.push_back(mk(4'h4, 4'h0, 64'h1, 64'h100, 64'h8, 64'h108, 0, 3'b010));
        vecs.push_back(mk(4'h6, 4'h7, 64'd1, 64'd1, 0, 64'd0, 0, 3'b010));
        vecs.push_back(mk(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 3'b001));
        vecs.push_back(mk(4'h7, 4'h6, 0, 0, 0, 64'd0, 0, 3'b001));
        vecs.push_back(mk(4'h7, 4'h1, 0, 0, 0, 64'd0, 1, 3'b001));
        vecs.push_back(mk(4'h7, 4'h5, 0, 0, 0, 64'd0, 0, 3'b001));
        vecs.push_back(mk(4'h8, 4'h0, 64'h7, 64'h100, 0, 64'hF8, 0, 3'b001));
        vecs.push_back(mk(4'h9, 4'h0, 64'h7, 64'h100, 0, 64'h108, 0, 3'b001));
        vecs.push_back(mk(4'h0, 4'h0, 64'd5, 64'd6, 64'd7, 64'd0, 0, 3'b001));
        vecs.push_back(mk(4'h7, 4'h9, 0, 0, 0, 64'd0, 0, 3'b001));
        vecs.push_back(mk(4'h2, 4'h0, 64'h77, 0, 0, 64'h77, 1, 3'b001));
        vecs.push_back(mk(4'h5, 4'h0, 64'h1, 64'h20, 64'h10, 64'h30, 0, 3'b001));
        vecs.push_back(mk(4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 64'd0, 0, 3'b101));
        vecs.push_back(mk(4'h7, 4'h2, 0, 0, 0, 64'd0, 1, 3'b101));
        vecs.push_back(mk(4'hC, 4'h0, 64'd1, 64'd1, 64'd1, 64'd0, 0, 3'b101));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_valE", valE_o, 0);
        chk("rst_cnd", Cnd_o, 0);
        chk("rst_icode", icode_o, 0);
        chk("rst_cc", cc_o, 3'b100);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid32", out_valid_s, 0);
        chk("rst_cc32", cc_s, 3'b100);
        rst_n_i = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready_o, 1);

        // Vector table, one instruction per two cycles
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].c);
            in_valid_i = 1'b1;
            out_ready_i = 1'b1;
            #1 chk($sformatf("vec%0d_in_ready", i), in_ready_o, 1);
            @(posedge clk);
            @(negedge clk);
            in_valid_i = 1'b0;
            chk($sformatf("vec%0d_valid", i), out_valid_o, 1);
            chk($sformatf("vec%0d_icode", i), icode_o, vecs[i].icode);
            chk($sformatf("vec%0d_valE", i), valE_o, vecs[i].e);
            chk($sformatf("vec%0d_cnd", i), Cnd_o, vecs[i].cnd);
            chk($sformatf("vec%0d_cc", i), cc_o, vecs[i].cc);
        end

        // Multiply -3 * 7: four busy cycles, result on the fifth edge
        @(negedge clk);
        drive(4'h6, 4'h4, -64'sd3, 64'd7, 0);
        in_valid_i = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid_i = 1'b0;
            chk($sformatf("mul_busy%0d", i), busy_o, 1);
            chk($sformatf("mul_in_ready%0d", i), in_ready_o, 0);
            chk($sformatf("mul_valid%0d", i), out_valid_o, 0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("mul_valid", out_valid_o, 1);
        chk("mul_valE", valE_o, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul_cc", cc_o, 3'b010);
        chk("mul_busy_done", busy_o, 0);

        // PUSHQ then POPQ with a 3-cycle output stall
        drive(4'hA, 4'h0, 0, 64'h100, 0);
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(4'hB, 4'h0, 0, 64'hF8, 0);
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall_valid%0d", i), out_valid_o, 1);
            chk($sformatf("stall_valE%0d", i), valE_o, 64'hF8);
            chk($sformatf("stall_in_ready%0d", i), in_ready_o, 0);
            chk($sformatf("stall_cc%0d", i), cc_o, 3'b010);
            @(negedge clk);
        end
        out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("pop_valid", out_valid_o, 1);
        chk("pop_icode", icode_o, 4'hB);
        chk("pop_valE", valE_o, 64'h100);
        chk("pop_cc", cc_o, 3'b010);

        // Reset in the second multiply cycle aborts with no beat
        @(negedge clk);
        drive(4'h6, 4'h4, 64'd9, 64'd9, 0);
        in_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        rst_n_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;
        chk("abort_valid", out_valid_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_cc", cc_o, 3'b100);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid_o) seen = 1'b1;
        end
        chk("abort_no_beat", seen, 0);

        // Randomized stream against the model, with random backpressure
        m_cc = 3'b100;
        pending = 1'b0;
        sent = 0; got = 0; cyc = 0;
        r_ic = '0; r_fn = '0; r_a = '0; r_b = '0; r_c = '0;
        while (got < 300 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!pending && sent < 300 && $urandom_range(0, 3) != 0) begin
                r_ic = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
                if (r_ic == 4'h6)
                    r_fn = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
                else
                    r_fn = 4'($urandom_range(0, 15));
                r_a = rnd64(); r_b = rnd64(); r_c = rnd64();
                pending = 1'b1;
            end
            in_valid_i = pending;
            drive(r_ic, r_fn, r_a, r_b, r_c);
            out_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_beat", 1, 0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    beat = {icode_o, Cnd_o, cc_o, valE_o};
                    chk($sformatf("rnd%0d_icode", got), beat[71:68], exp_beat[71:68]);
                    chk($sformatf("rnd%0d_cnd", got), beat[67], exp_beat[67]);
                    chk($sformatf("rnd%0d_cc", got), beat[66:64], exp_beat[66:64]);
                    chk($sformatf("rnd%0d_valE", got), beat[63:0], exp_beat[63:0]);
                end
                got++;
            end
            if (in_valid_i && in_ready_o) begin
                model(r_ic, r_fn, r_a, r_b, r_c, exp_beat);
                exp_q.push_back(exp_beat);
                pending = 1'b0;
                sent++;
            end
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        chk("rnd_beats_received", got, 300);

        // 32-bit instance with 8 multiply cycles
        @(negedge clk);
        icode_s = 4'h6; ifun_s = 4'h4; valA_s = 32'h0001_0000; valB_s = 32'h0001_0000; valC_s = '0;
        in_valid_s = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid_s = 1'b0;
            chk($sformatf("w32_busy%0d", i), busy_s, 1);
            @(posedge clk);
        end
        @(negedge clk);
        chk("w32_mul_valid", out_valid_s, 1);
        chk("w32_mul_valE", valE_s, 32'h0);
        chk("w32_mul_cc", cc_s, 3'b100);
        icode_s = 4'h8; ifun_s = 4'h0; valA_s = '0; valB_s = 32'h40;
        in_valid_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_s = 1'b0;
        chk("w32_call_valid", out_valid_s, 1);
        chk("w32_call_valE", valE_s, 32'h3C);
        chk("w32_call_icode", icode_os, 4'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
